video_timing_gen: RTL and testbench

// Raster timing source: emits pix_ce, hblank, vblank, hs, vs and pixel coordinates.

---
 rtl/video_timing_gen.sv | 141 ++++++++++++++
 tb/tb_video_timing_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel strobe, blanking, syncs, coordinates and an optional test pattern.
// Define VTG_PATTERN_EN to build the colour-bar generator; otherwise the colour outputs are tied to zero.
module video_timing_gen #(
    parameter int   H_ACTIVE    = 320,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 32,
    parameter int   H_BP        = 40,
    parameter int   V_ACTIVE    = 240,
    parameter int   V_FP        = 3,
    parameter int   V_SYNC      = 4,
    parameter int   V_BP        = 15,
    parameter int   CE_DIV      = 4,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   VIDEO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic                   pix_ce,
    output logic                   hblank,
    output logic                   vblank,
    output logic                   hs,
    output logic                   vs,
    output logic [11:0]            hcount,
    output logic [11:0]            vcount,
    output logic                   frame_start,
    output logic [VIDEO_DEPTH-1:0] red,
    output logic [VIDEO_DEPTH-1:0] green,
    output logic [VIDEO_DEPTH-1:0] blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    if (H_TOTAL > 4096) begin : g_h_total_check
        $error("video_timing_gen: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : g_v_total_check
        $error("video_timing_gen: V_TOTAL exceeds 4096");
    end
    if (CE_DIV < 1) begin : g_ce_div_check
        $error("video_timing_gen: CE_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div;
    logic             strobe;
    logic [11:0]      h_nxt;
    logic [11:0]      v_nxt;

    assign strobe = enable && (div == DIV_W'(CE_DIV - 1));

    always_comb begin
        h_nxt = hcount + 12'd1;
        v_nxt = vcount;
        if (hcount == 12'(H_TOTAL - 1)) begin
            h_nxt = 12'd0;
            v_nxt = (vcount == 12'(V_TOTAL - 1)) ? 12'd0 : vcount + 12'd1;
        end
    end

    // Flags are computed from the position being entered so they land on the same edge as pix_ce.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            hcount      <= 12'd0;
            vcount      <= 12'd0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            pix_ce      <= 1'b0;
            frame_start <= 1'b0;
            if (strobe) begin
                div         <= '0;
                pix_ce      <= 1'b1;
                hcount      <= h_nxt;
                vcount      <= v_nxt;
                hblank      <= (h_nxt >= 12'(H_ACTIVE));
                vblank      <= (v_nxt >= 12'(V_ACTIVE));
                hs          <= ((h_nxt >= 12'(H_ACTIVE + H_FP)) &&
                                (h_nxt <  12'(H_ACTIVE + H_FP + H_SYNC))) ? HS_POL : ~HS_POL;
                vs          <= ((v_nxt >= 12'(V_ACTIVE + V_FP)) &&
                                (v_nxt <  12'(V_ACTIVE + V_FP + V_SYNC))) ? VS_POL : ~VS_POL;
                frame_start <= (h_nxt == 12'd0) && (v_nxt == 12'd0);
            end else if (enable) begin
                div <= div + DIV_W'(1);
            end
        end
    end

`ifdef VTG_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [2:0]  bar;
    logic [2:0]  bar_nxt;
    logic [11:0] bar_cnt;
    logic [11:0] bar_cnt_nxt;
    logic        active_nxt;

    // Bar index walks by counting pixels; the last bar absorbs any remainder.
    always_comb begin
        bar_nxt     = bar;
        bar_cnt_nxt = bar_cnt + 12'd1;
        if (h_nxt == 12'd0) begin
            bar_nxt     = 3'd0;
            bar_cnt_nxt = 12'd0;
        end else if ((bar_cnt == 12'(BAR_W - 1)) && (bar != 3'd7)) begin
            bar_nxt     = bar + 3'd1;
            bar_cnt_nxt = 12'd0;
        end
    end

    assign active_nxt = (h_nxt < 12'(H_ACTIVE)) && (v_nxt < 12'(V_ACTIVE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar     <= 3'd0;
            bar_cnt <= 12'd0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else if (strobe) begin
            bar     <= bar_nxt;
            bar_cnt <= bar_cnt_nxt;
            red     <= active_nxt ? {VIDEO_DEPTH{~bar_nxt[1]}} : '0;
            green   <= active_nxt ? {VIDEO_DEPTH{~bar_nxt[2]}} : '0;
            blue    <= active_nxt ? {VIDEO_DEPTH{~bar_nxt[0]}} : '0;
        end
    end
`else
    assign red   = '0;
    assign green = '0;
    assign blue  = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 24x12 raster with CE_DIV=2, plus a CE_DIV=1 instance.
module tb_video_timing_gen;

    localparam int H_TOTAL = 24;
    localparam int V_TOTAL = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        en1 = 1'b1;

    logic        pix_ce, hblank, vblank, hs, vs, frame_start;
    logic [11:0] hcount, vcount;
    logic [7:0]  red, green, blue;

    logic        pix_ce1, hblank1, vblank1, hs1, vs1, frame_start1;
    logic [11:0] hcount1, vcount1;
    logic [7:0]  red1, green1, blue1;

    int errors = 0;
    int checks = 0;
    int eh = 0;
    int ev = 0;

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CE_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .VIDEO_DEPTH(8)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_ce(pix_ce),
        .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs),
        .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
        .red(red), .green(green), .blue(blue)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CE_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0), .VIDEO_DEPTH(8)
    ) u_dut_div1 (
        .clk(clk), .reset_n(reset_n), .enable(en1), .pix_ce(pix_ce1),
        .hblank(hblank1), .vblank(vblank1), .hs(hs1), .vs(vs1),
        .hcount(hcount1), .vcount(vcount1), .frame_start(frame_start1),
        .red(red1), .green(green1), .blue(blue1)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge following a strobe, with the model advanced to the new pixel.
    task automatic next_strobe();
        int n = 0;
        @(negedge clk);
        while (pix_ce !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (pix_ce !== 1'b1) begin
            checks++; errors++;
            $display("FAIL strobe_timeout: pix_ce=%b required 1", pix_ce);
        end
        eh = (eh + 1) % H_TOTAL;
        if (eh == 0) ev = (ev + 1) % V_TOTAL;
    endtask

    task automatic check_position(input string tag);
        logic exp_hb, exp_vb, exp_hs, exp_vs;
        exp_hb = (eh >= 16);
        exp_vb = (ev >= 8);
        exp_hs = !(eh >= 18 && eh <= 21);
        exp_vs = !(ev == 9 || ev == 10);
        checks++;
        if (hcount !== 12'(eh) || vcount !== 12'(ev)) begin
            errors++;
            $display("FAIL %s_pos: got (%0d,%0d) required (%0d,%0d)", tag, hcount, vcount, eh, ev);
        end
        checks++;
        if (hblank !== exp_hb || vblank !== exp_vb) begin
            errors++;
            $display("FAIL %s_blank at (%0d,%0d): got hb=%b vb=%b required hb=%b vb=%b",
                     tag, eh, ev, hblank, vblank, exp_hb, exp_vb);
        end
        checks++;
        if (hs !== exp_hs || vs !== exp_vs) begin
            errors++;
            $display("FAIL %s_sync at (%0d,%0d): got hs=%b vs=%b required hs=%b vs=%b",
                     tag, eh, ev, hs, vs, exp_hs, exp_vs);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_ce, frame_start, hblank, vblank, hs, vs} !== 6'b000011) begin
            errors++;
            $display("FAIL reset_flags: got ce,fs,hb,vb,hs,vs=%b required 000011",
                     {pix_ce, frame_start, hblank, vblank, hs, vs});
        end
        checks++;
        if (hcount !== 12'd0 || vcount !== 12'd0 || red !== 8'd0) begin
            errors++;
            $display("FAIL reset_pos: got (%0d,%0d) red=%h required (0,0) red=00", hcount, vcount, red);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_divider();
        @(negedge clk);
        checks++;
        if (pix_ce !== 1'b0) begin
            errors++;
            $display("FAIL div_first_edge: pix_ce=%b required 0", pix_ce);
        end
        @(negedge clk);
        checks++;
        if (pix_ce !== 1'b1 || hcount !== 12'd1 || vcount !== 12'd0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL div_first_strobe: ce=%b (%0d,%0d) fs=%b required ce=1 (1,0) fs=0",
                     pix_ce, hcount, vcount, frame_start);
        end
        @(negedge clk);
        checks++;
        if (pix_ce !== 1'b0 || hcount !== 12'd1) begin
            errors++;
            $display("FAIL div_hold: ce=%b hcount=%0d required ce=0 hcount=1", pix_ce, hcount);
        end
    endtask

    task automatic test_frame();
        int n_str = 1;
        int clks = 0;
        int bad = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (pix_ce === 1'b1) n_str++;
            if (pix_ce === 1'b1 && prev === 1'b1) bad++;
            prev = pix_ce;
            if (frame_start === 1'b1) break;
        end
        checks++;
        if (n_str !== 288) begin
            errors++;
            $display("FAIL frame_first_strobes: got %0d required 288", n_str);
        end
        n_str = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            clks++;
            if (pix_ce === 1'b1) n_str++;
            if (pix_ce === 1'b1 && prev === 1'b1) bad++;
            if (frame_start === 1'b1 && pix_ce !== 1'b1) bad++;
            prev = pix_ce;
            if (frame_start === 1'b1) break;
        end
        checks++;
        if (n_str !== 288 || clks !== 576) begin
            errors++;
            $display("FAIL frame_period: got %0d strobes %0d clks required 288 strobes 576 clks", n_str, clks);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL frame_strobe_shape: got %0d violations required 0", bad);
        end
        eh = 0;
        ev = 0;
        check_position("frame_origin");
    endtask

    task automatic test_line();
        for (int i = 0; i < H_TOTAL; i++) begin
            next_strobe();
            check_position("line");
            @(negedge clk);
            checks++;
            if (pix_ce !== 1'b0 || frame_start !== 1'b0 || hcount !== 12'(eh) ||
                hblank !== (eh >= 16) || hs !== !(eh >= 18 && eh <= 21)) begin
                errors++;
                $display("FAIL line_between at h=%0d: ce=%b fs=%b hcount=%0d hb=%b hs=%b",
                         eh, pix_ce, frame_start, hcount, hblank, hs);
            end
        end
    endtask

    task automatic test_vertical();
        for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
            next_strobe();
            check_position("frame");
        end
    endtask

    task automatic test_enable();
        int guard = 0;
        while (eh != 5 && guard < 100) begin
            next_strobe();
            guard++;
        end
        check_position("en_pre");
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (pix_ce !== 1'b0) begin
                errors++;
                $display("FAIL en_off_ce cycle %0d: pix_ce=%b required 0", i, pix_ce);
            end
            check_position("en_off");
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ce !== 1'b0 || hcount !== 12'd5) begin
            errors++;
            $display("FAIL en_resume_wait: ce=%b hcount=%0d required ce=0 hcount=5", pix_ce, hcount);
        end
        @(negedge clk);
        eh = 6;
        checks++;
        if (pix_ce !== 1'b1) begin
            errors++;
            $display("FAIL en_resume_strobe: pix_ce=%b required 1", pix_ce);
        end
        check_position("en_resume");
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(eh == 13 && ev == 4) && guard < 400) begin
            next_strobe();
            guard++;
        end
        check_position("rst_pre");
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (hcount !== 12'd0 || vcount !== 12'd0 || pix_ce !== 1'b0 ||
            {frame_start, hblank, vblank, hs, vs} !== 5'b00011) begin
            errors++;
            $display("FAIL rst_async: (%0d,%0d) ce=%b fs,hb,vb,hs,vs=%b required (0,0) ce=0 00011",
                     hcount, vcount, pix_ce, {frame_start, hblank, vblank, hs, vs});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ce !== 1'b0 || hcount !== 12'd0) begin
            errors++;
            $display("FAIL rst_release_wait: ce=%b hcount=%0d required ce=0 hcount=0", pix_ce, hcount);
        end
        @(negedge clk);
        eh = 1;
        ev = 0;
        checks++;
        if (pix_ce !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_strobe: pix_ce=%b required 1", pix_ce);
        end
        check_position("rst_post");
    endtask

    task automatic test_ce_div1();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            checks++;
            if (pix_ce1 !== 1'b1 || hcount1 !== 12'(i % H_TOTAL) || vcount1 !== 12'(i / H_TOTAL)) begin
                errors++;
                $display("FAIL div1_clk%0d: ce=%b (%0d,%0d) required ce=1 (%0d,%0d)",
                         i, pix_ce1, hcount1, vcount1, i % H_TOTAL, i / H_TOTAL);
            end
        end
    endtask

    task automatic test_pattern();
        logic [2:0] bars [8];
        logic [2:0] rgb;
        int n = 0;
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        while (!(pix_ce === 1'b1 && frame_start === 1'b1) && n < 700) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL pattern_sync: frame_start=%b required 1", frame_start);
        end
        eh = 0;
        ev = 0;
        for (int i = 0; i < H_TOTAL; i++) begin
            if (i != 0) next_strobe();
`ifdef VTG_PATTERN_EN
            rgb = (eh < 16) ? bars[eh / 2] : 3'b000;
`else
            rgb = 3'b000;
`endif
            checks++;
            if (red !== {8{rgb[2]}} || green !== {8{rgb[1]}} || blue !== {8{rgb[0]}}) begin
                errors++;
                $display("FAIL pattern h=%0d: got %h,%h,%h required %h,%h,%h", eh, red, green, blue,
                         {8{rgb[2]}}, {8{rgb[1]}}, {8{rgb[0]}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_frame();
        test_line();
        test_vertical();
        test_enable();
        test_reset_mid();
        test_ce_div1();
        test_pattern();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
